// File: rtl/int_div_base.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, nbits cycles per
// operand pair, with val/rdy handshakes on both the operand and result streams.
module int_div_base #(
    parameter int nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               istream_val,
    output logic               istream_rdy,
    input  logic [2*nbits-1:0] istream_msg,
    output logic               ostream_val,
    input  logic               ostream_rdy,
    output logic [2*nbits-1:0] ostream_msg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int            CW   = $clog2(nbits + 1);
    localparam logic [CW-1:0] LAST = CW'(nbits - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nx;
    logic [nbits-1:0] r_quo;
    logic [nbits-1:0] r_rem;
    logic [nbits-1:0] r_dvs;
    logic [nbits-1:0] w_quo_nx;
    logic [nbits-1:0] w_rem_nx;
    logic [nbits-1:0] w_dvs_nx;
    logic [nbits:0]   w_t;
    logic             w_ge;
    logic [nbits-1:0] w_sub;

    // Compare is nbits+1 wide; the difference is < divisor, so its low nbits are exact.
    assign w_t   = {r_rem, r_quo[nbits-1]};
    assign w_ge  = (w_t >= {1'b0, r_dvs});
    assign w_sub = w_t[nbits-1:0] - r_dvs;

    assign istream_rdy = (r_state == IDLE);
    assign ostream_val = (r_state == DONE);
    assign ostream_msg = {r_rem, r_quo};

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_quo_nx   = r_quo;
        w_rem_nx   = r_rem;
        w_dvs_nx   = r_dvs;
        case (r_state)
            IDLE: begin
                if (istream_val) begin
                    w_quo_nx   = istream_msg[2*nbits-1:nbits];
                    w_dvs_nx   = istream_msg[nbits-1:0];
                    w_rem_nx   = {nbits{1'b0}};
                    w_cnt_nx   = {CW{1'b0}};
                    w_state_nx = CALC;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            CALC: begin
                w_rem_nx = w_ge ? w_sub : w_t[nbits-1:0];
                w_quo_nx = {r_quo[nbits-2:0], w_ge};
                w_cnt_nx = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_state_nx = DONE;
                end else begin
                    w_state_nx = CALC;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    w_state_nx = IDLE;
                end else begin
                    w_state_nx = DONE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
            r_quo   <= {nbits{1'b0}};
            r_rem   <= {nbits{1'b0}};
            r_dvs   <= {nbits{1'b0}};
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_quo   <= w_quo_nx;
            r_rem   <= w_rem_nx;
            r_dvs   <= w_dvs_nx;
        end
    end

endmodule

// File: tb/tb_int_div_base.sv
// Bench for int_div_base: directed vector table, handshake corner cases, reset abort
// and randomized traffic checked against a q=a/b, r=a%b scoreboard.
module tb_int_div_base;

    logic        clk;
    logic        reset;
    logic        istream_val;
    logic        istream_rdy;
    logic [63:0] istream_msg;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [63:0] ostream_msg;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int_div_base #(.nbits(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t        tbl[7];
    logic [63:0] sb_q[$];
    logic [63:0] out_log[$];
    logic [63:0] last_out;
    int          in_cyc;
    int          out_cnt;
    bit          mon_en;
    bit          rdy_bad;
    bit          val_seen;
    bit          exp_rdy_next;

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Scoreboard step, evaluated on every falling edge while inputs are stable.
    task automatic mon_step();
        if (exp_rdy_next) begin
            chk("rdy_after_out_fire", 64'(istream_rdy), 64'd1);
            exp_rdy_next = 1'b0;
        end
        if (sb_q.size() != 0 && istream_rdy) rdy_bad = 1'b1;
        if (istream_val && istream_rdy) begin
            chk("accept_only_when_empty", 64'(sb_q.size()), 64'd0);
            sb_q.push_back(golden(istream_msg[63:32], istream_msg[31:0]));
            in_cyc   = cyc;
            rdy_bad  = 1'b0;
            val_seen = 1'b0;
        end
        if (ostream_val) begin
            if (sb_q.size() == 0) begin
                fail_now("spurious_result");
            end else begin
                if (!val_seen) begin
                    val_seen = 1'b1;
                    chk("latency", 64'(cyc - in_cyc), 64'd33);
                end
                chk("result_msg", ostream_msg, sb_q[0]);
                if (ostream_rdy) begin
                    chk("istream_rdy_low_while_busy", 64'(rdy_bad), 64'd0);
                    void'(sb_q.pop_front());
                    out_log.push_back(ostream_msg);
                    last_out     = ostream_msg;
                    out_cnt++;
                    exp_rdy_next = 1'b1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) mon_step();
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        istream_val = 1'b1;
        istream_msg = {a, b};
        @(negedge clk);
        while (!istream_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail_now("timeout_istream_rdy");
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        istream_msg = {$urandom, $urandom};
    endtask

    task automatic recv(input int hold);
        int n = 0;
        ostream_rdy = (hold == 0);
        while (!ostream_val && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("timeout_ostream_val");
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            ostream_rdy = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'd100,         32'd7,          64'h00000002_0000000E, 0};
        tbl[1] = '{32'h1234_5678,   32'd0,          64'h12345678_FFFFFFFF, 0};
        tbl[2] = '{32'h8000_0000,   32'd3,          64'h00000002_2AAAAAAA, 10};
        tbl[3] = '{32'd0,           32'd5,          64'h00000000_00000000, 0};
        tbl[4] = '{32'hFFFF_FFFF,   32'hFFFF_FFFF,  64'h00000000_00000001, 0};
        tbl[5] = '{32'hFFFF_FFFF,   32'd16,         64'h0000000F_0FFFFFFF, 2};
        tbl[6] = '{32'd7,           32'd0,          64'h00000007_FFFFFFFF, 1};

        reset        = 1'b0;
        istream_val  = 1'b0;
        istream_msg  = 64'd0;
        ostream_rdy  = 1'b0;
        mon_en       = 1'b0;
        rdy_bad      = 1'b0;
        val_seen     = 1'b0;
        exp_rdy_next = 1'b0;
        out_cnt      = 0;
        in_cyc       = 0;
        last_out     = 64'd0;
        #2;
        chk("reset_istream_rdy", 64'(istream_rdy), 64'd1);
        chk("reset_ostream_val", 64'(ostream_val), 64'd0);
        chk("reset_ostream_msg", ostream_msg, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].a, tbl[i].b);
            recv(tbl[i].hold);
            chk($sformatf("table_%0d", i), last_out, tbl[i].exp);
        end

        // Source holds val high across two operand pairs back to back.
        out_log.delete();
        fork
            begin
                send(32'd5, 32'd9);
                send(32'hFFFF_FFFF, 32'd1);
            end
            begin
                recv(0);
                recv(0);
            end
        join
        chk("b2b_count", 64'(out_log.size()), 64'd2);
        if (out_log.size() == 2) begin
            chk("b2b_first", out_log[0], 64'h00000005_00000000);
            chk("b2b_second", out_log[1], 64'h00000000_FFFFFFFF);
        end

        // Abort 1000/3 partway through CALC, then rerun it.
        send(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #3;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("abort_istream_rdy", 64'(istream_rdy), 64'd1);
        chk("abort_ostream_val", 64'(ostream_val), 64'd0);
        chk("abort_ostream_msg", ostream_msg, 64'd0);
        @(posedge clk);
        #1;
        reset        = 1'b1;
        sb_q.delete();
        rdy_bad      = 1'b0;
        val_seen     = 1'b0;
        exp_rdy_next = 1'b0;
        mon_en       = 1'b1;
        send(32'd1000, 32'd3);
        recv(0);
        chk("after_abort_1000_3", last_out, 64'h00000001_0000014D);

        // Randomized traffic with source gaps and sink backpressure.
        begin
            int target;
            target = out_cnt + 500;
            fork
                begin
                    for (int i = 0; i < 500; i++) begin
                        logic [31:0] a;
                        logic [31:0] b;
                        repeat ($urandom_range(0, 3)) begin
                            @(posedge clk);
                            #1;
                            istream_msg = {$urandom, $urandom};
                        end
                        if ($urandom_range(0, 4) == 0) begin
                            a = $urandom_range(0, 1000);
                            b = 32'd1001 + $urandom_range(0, 100000);
                        end else begin
                            a = pick_op();
                            b = pick_op();
                        end
                        send(a, b);
                    end
                end
                begin
                    int guard = 0;
                    while (out_cnt < target && guard < 60000) begin
                        @(posedge clk);
                        #1;
                        ostream_rdy = 1'($urandom_range(0, 1));
                        guard++;
                    end
                    if (guard >= 60000) fail_now("timeout_random_drain");
                end
            join
            chk("random_result_count", 64'(out_cnt), 64'(target));
        end
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
